// File: rtl/uart_rx_fifo.sv
// Receive FIFO for a UART: buffers characters with their status bits and derives
// the host-facing level, trigger, error-presence, overrun and character-timeout flags.
module uart_rx_fifo #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ERR_W  = 3,
  parameter int unsigned TO_CYC = 1024,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              fifo_en,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ERR_W-1:0]  wr_err,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic [ERR_W-1:0]  rd_err,
  output logic              rd_valid,
  input  logic [AW:0]       trig_lvl,
  output logic [AW:0]       count,
  output logic              full,
  output logic              empty,
  output logic              trigger,
  output logic              overrun,
  input  logic              ovr_clr,
  output logic              err_in_fifo,
  output logic              timeout
);

  localparam int unsigned EntryW = DATA_W + ERR_W;
  localparam int unsigned ToW    = $clog2(TO_CYC + 1);
  localparam logic [AW:0]  PtrOne = (AW+1)'(1);
  localparam logic [AW:0]  DepthFull = (AW+1)'(DEPTH);
  localparam logic [ToW-1:0] ToMax = ToW'(TO_CYC);
  localparam logic [ToW-1:0] ToOne = ToW'(1);

  logic [EntryW-1:0] mem_q [DEPTH];

  logic [AW:0]       wr_ptr_q, wr_ptr_d;
  logic [AW:0]       rd_ptr_q, rd_ptr_d;
  logic [AW:0]       err_cnt_q, err_cnt_d;
  logic [ToW-1:0]    to_cnt_q, to_cnt_d;
  logic              overrun_q, overrun_d;
  logic              rd_valid_q, rd_valid_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic [ERR_W-1:0]  rd_err_q, rd_err_d;
  logic              fifo_en_q;
  logic [AW:0]       trig_lvl_q;

  logic [AW:0]       count_w;
  logic [AW:0]       eff_depth;
  logic [AW:0]       trig_eff;
  logic              full_w, empty_w;
  logic              flush;
  logic              rd_acc, wr_acc, wr_drop;
  logic [EntryW-1:0] rd_entry;
  logic [ERR_W-1:0]  rd_entry_err;

  // Mode and trigger level are registered so the status flags depend on state only.
  assign count_w   = wr_ptr_q - rd_ptr_q;
  assign eff_depth = fifo_en_q ? DepthFull : PtrOne;
  assign full_w    = (count_w == eff_depth);
  assign empty_w   = (count_w == '0);
  assign trig_eff  = (trig_lvl_q == '0) ? PtrOne : trig_lvl_q;

  assign flush   = clr || (fifo_en != fifo_en_q);
  assign rd_acc  = rd_en && !empty_w;
  assign wr_acc  = wr_en && (!full_w || rd_acc);
  assign wr_drop = wr_en && full_w && !rd_acc;

  assign rd_entry     = mem_q[rd_ptr_q[AW-1:0]];
  assign rd_entry_err = rd_entry[DATA_W +: ERR_W];

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    err_cnt_d  = err_cnt_q;
    to_cnt_d   = to_cnt_q;
    overrun_d  = overrun_q;
    rd_valid_d = 1'b0;
    rd_data_d  = rd_data_q;
    rd_err_d   = rd_err_q;

    if (flush) begin
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      err_cnt_d = '0;
      to_cnt_d  = '0;
      overrun_d = 1'b0;
    end else begin
      if (wr_acc) begin
        wr_ptr_d = wr_ptr_q + PtrOne;
      end
      if (rd_acc) begin
        rd_ptr_d   = rd_ptr_q + PtrOne;
        rd_valid_d = 1'b1;
        rd_data_d  = rd_entry[DATA_W-1:0];
        rd_err_d   = rd_entry_err;
      end

      unique case ({wr_acc && (wr_err != '0), rd_acc && (rd_entry_err != '0)})
        2'b10:   err_cnt_d = err_cnt_q + PtrOne;
        2'b01:   err_cnt_d = err_cnt_q - PtrOne;
        default: err_cnt_d = err_cnt_q;
      endcase

      if (rd_acc || wr_acc || empty_w) begin
        to_cnt_d = '0;
      end else if (to_cnt_q != ToMax) begin
        to_cnt_d = to_cnt_q + ToOne;
      end

      // A fresh drop wins over a same-cycle clear request.
      if (wr_drop) begin
        overrun_d = 1'b1;
      end else if (ovr_clr) begin
        overrun_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      err_cnt_q  <= '0;
      to_cnt_q   <= '0;
      overrun_q  <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      rd_err_q   <= '0;
      fifo_en_q  <= fifo_en;
      trig_lvl_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      err_cnt_q  <= err_cnt_d;
      to_cnt_q   <= to_cnt_d;
      overrun_q  <= overrun_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      rd_err_q   <= rd_err_d;
      fifo_en_q  <= fifo_en;
      trig_lvl_q <= trig_lvl;
    end
  end

  // Storage has no reset; occupancy is tracked entirely by the pointers.
  always_ff @(posedge clk) begin
    if (!reset && !flush && wr_acc) begin
      mem_q[wr_ptr_q[AW-1:0]] <= {wr_err, wr_data};
    end
  end

  assign rd_data     = rd_data_q;
  assign rd_err      = rd_err_q;
  assign rd_valid    = rd_valid_q;
  assign count       = count_w;
  assign full        = full_w;
  assign empty       = empty_w;
  assign trigger     = (count_w >= trig_eff);
  assign overrun     = overrun_q;
  assign err_in_fifo = (err_cnt_q != '0);
  assign timeout     = (to_cnt_q == ToMax);

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: ordering, overrun, trigger, error tracking,
// timeout, holding-register mode, back-to-back traffic and reset.
module tb_uart_rx_fifo;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned DEPTH  = 16;
  localparam int unsigned ERR_W  = 3;
  localparam int unsigned TO_CYC = 8;
  localparam int unsigned AW     = 4;

  logic              clk = 1'b0;
  logic              reset, clr, fifo_en, wr_en, rd_en, ovr_clr;
  logic [DATA_W-1:0] wr_data;
  logic [ERR_W-1:0]  wr_err;
  logic [AW:0]       trig_lvl;
  logic [DATA_W-1:0] rd_data;
  logic [ERR_W-1:0]  rd_err;
  logic              rd_valid, full, empty, trigger, overrun, err_in_fifo, timeout;
  logic [AW:0]       count;

  int checks = 0;
  int errors = 0;

  uart_rx_fifo #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH),
    .ERR_W (ERR_W),
    .TO_CYC(TO_CYC)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .clr        (clr),
    .fifo_en    (fifo_en),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .wr_err     (wr_err),
    .rd_en      (rd_en),
    .rd_data    (rd_data),
    .rd_err     (rd_err),
    .rd_valid   (rd_valid),
    .trig_lvl   (trig_lvl),
    .count      (count),
    .full       (full),
    .empty      (empty),
    .trigger    (trigger),
    .overrun    (overrun),
    .ovr_clr    (ovr_clr),
    .err_in_fifo(err_in_fifo),
    .timeout    (timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_char(input logic [7:0] d, input logic [2:0] e);
    wr_en = 1'b1; wr_data = d; wr_err = e;
    step();
    wr_en = 1'b0; wr_err = '0;
  endtask

  task automatic read_pulse();
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; clr = 1'b1; wr_en = 1'b1; rd_en = 1'b1; ovr_clr = 1'b1;
    wr_data = 8'hFF; wr_err = 3'b111;
    step(); step();
    reset = 1'b0; clr = 1'b0; wr_en = 1'b0; rd_en = 1'b0; ovr_clr = 1'b0; wr_err = '0;
    checks++; if (rd_data !== 8'h00) begin errors++; $display("FAIL rst_rd_data got %0h want 0", rd_data); end
    checks++; if (rd_err !== 3'b000) begin errors++; $display("FAIL rst_rd_err got %0b want 0", rd_err); end
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL rst_rd_valid got %0b want 0", rd_valid); end
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL rst_count got %0d want 0", count); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL rst_empty got %0b want 1", empty); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL rst_full got %0b want 0", full); end
    checks++; if (trigger !== 1'b0) begin errors++; $display("FAIL rst_trigger got %0b want 0", trigger); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL rst_overrun got %0b want 0", overrun); end
    checks++; if (err_in_fifo !== 1'b0) begin errors++; $display("FAIL rst_err_in_fifo got %0b want 0", err_in_fifo); end
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL rst_timeout got %0b want 0", timeout); end
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < 16; i++) write_char(8'(i), 3'b000);
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL fill_full got %0b want 1", full); end
    checks++; if (count !== 5'd16) begin errors++; $display("FAIL fill_count got %0d want 16", count); end
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL fill_rd_valid got %0b want 0", rd_valid); end
    for (int i = 0; i < 16; i++) begin
      read_pulse();
      checks++; if (rd_valid !== 1'b1) begin errors++; $display("FAIL drain_valid[%0d] got %0b want 1", i, rd_valid); end
      checks++; if (rd_data !== 8'(i)) begin errors++; $display("FAIL drain_data[%0d] got %0h want %0h", i, rd_data, i); end
      step();
      checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL drain_pulse[%0d] got %0b want 0", i, rd_valid); end
    end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL drain_empty got %0b want 1", empty); end
  endtask

  task automatic test_overrun();
    for (int i = 0; i < 16; i++) write_char(8'(8'h10 + i), 3'b000);
    write_char(8'hAA, 3'b000);
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_set got %0b want 1", overrun); end
    checks++; if (count !== 5'd16) begin errors++; $display("FAIL ovr_count got %0d want 16", count); end
    ovr_clr = 1'b1;
    write_char(8'hBB, 3'b000);
    ovr_clr = 1'b0;
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_clr_vs_set got %0b want 1", overrun); end
    ovr_clr = 1'b1; step(); ovr_clr = 1'b0;
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_clr got %0b want 0", overrun); end
    for (int i = 0; i < 16; i++) begin
      read_pulse();
      checks++; if (rd_data !== 8'(8'h10 + i)) begin errors++; $display("FAIL ovr_data[%0d] got %0h want %0h", i, rd_data, 8'h10 + i); end
    end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL ovr_empty got %0b want 1", empty); end
  endtask

  task automatic test_trigger();
    trig_lvl = 5'd4;
    step();
    for (int i = 0; i < 3; i++) write_char(8'(8'h30 + i), 3'b000);
    checks++; if (trigger !== 1'b0) begin errors++; $display("FAIL trig_3 got %0b want 0", trigger); end
    write_char(8'h33, 3'b000);
    checks++; if (trigger !== 1'b1) begin errors++; $display("FAIL trig_4 got %0b want 1", trigger); end
    read_pulse();
    checks++; if (trigger !== 1'b0) begin errors++; $display("FAIL trig_rd got %0b want 0", trigger); end
    repeat (3) read_pulse();
    checks++; if (rd_data !== 8'h33) begin errors++; $display("FAIL trig_last got %0h want 33", rd_data); end
  endtask

  task automatic test_err();
    write_char(8'h40, 3'b000);
    write_char(8'h41, 3'b001);
    write_char(8'h42, 3'b000);
    checks++; if (err_in_fifo !== 1'b1) begin errors++; $display("FAIL err_set got %0b want 1", err_in_fifo); end
    read_pulse();
    checks++; if (rd_err !== 3'b000) begin errors++; $display("FAIL err_rd0 got %0b want 000", rd_err); end
    checks++; if (err_in_fifo !== 1'b1) begin errors++; $display("FAIL err_hold got %0b want 1", err_in_fifo); end
    read_pulse();
    checks++; if (rd_data !== 8'h41) begin errors++; $display("FAIL err_data got %0h want 41", rd_data); end
    checks++; if (rd_err !== 3'b001) begin errors++; $display("FAIL err_rd1 got %0b want 001", rd_err); end
    checks++; if (err_in_fifo !== 1'b0) begin errors++; $display("FAIL err_clear got %0b want 0", err_in_fifo); end
    read_pulse();
    checks++; if (rd_err !== 3'b000) begin errors++; $display("FAIL err_rd2 got %0b want 000", rd_err); end
  endtask

  task automatic test_timeout();
    write_char(8'h5A, 3'b000);
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL to_start got %0b want 0", timeout); end
    repeat (7) step();
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL to_7 got %0b want 0", timeout); end
    step();
    checks++; if (timeout !== 1'b1) begin errors++; $display("FAIL to_8 got %0b want 1", timeout); end
    step();
    checks++; if (timeout !== 1'b1) begin errors++; $display("FAIL to_sat got %0b want 1", timeout); end
    read_pulse();
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL to_rd got %0b want 0", timeout); end
    checks++; if (rd_data !== 8'h5A) begin errors++; $display("FAIL to_data got %0h want 5a", rd_data); end
  endtask

  task automatic test_hold_mode();
    fifo_en = 1'b0;
    step();
    write_char(8'h11, 3'b000);
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL hold_full got %0b want 1", full); end
    checks++; if (count !== 5'd1) begin errors++; $display("FAIL hold_count got %0d want 1", count); end
    write_char(8'h22, 3'b000);
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL hold_ovr got %0b want 1", overrun); end
    read_pulse();
    checks++; if (rd_data !== 8'h11) begin errors++; $display("FAIL hold_data got %0h want 11", rd_data); end
    write_char(8'h55, 3'b000);
    clr = 1'b1;
    write_char(8'h33, 3'b000);
    clr = 1'b0;
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL hold_clr_count got %0d want 0", count); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL hold_clr_empty got %0b want 1", empty); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL hold_clr_ovr got %0b want 0", overrun); end
    read_pulse();
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL empty_rd_valid got %0b want 0", rd_valid); end
    checks++; if (rd_data !== 8'h11) begin errors++; $display("FAIL empty_rd_hold got %0h want 11", rd_data); end
  endtask

  task automatic test_back_to_back();
    fifo_en = 1'b1;
    step();
    write_char(8'h01, 3'b000);
    rd_en = 1'b1;
    write_char(8'h02, 3'b000);
    checks++; if (rd_data !== 8'h01) begin errors++; $display("FAIL b2b_data0 got %0h want 01", rd_data); end
    checks++; if (count !== 5'd1) begin errors++; $display("FAIL b2b_count0 got %0d want 1", count); end
    write_char(8'h03, 3'b000);
    rd_en = 1'b0;
    checks++; if (rd_data !== 8'h02) begin errors++; $display("FAIL b2b_data1 got %0h want 02", rd_data); end
    for (int i = 0; i < 15; i++) write_char(8'(8'h60 + i), 3'b000);
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL b2b_full got %0b want 1", full); end
    rd_en = 1'b1;
    write_char(8'h77, 3'b000);
    rd_en = 1'b0;
    checks++; if (rd_data !== 8'h03) begin errors++; $display("FAIL b2b_full_data got %0h want 03", rd_data); end
    checks++; if (count !== 5'd16) begin errors++; $display("FAIL b2b_full_count got %0d want 16", count); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL b2b_full_ovr got %0b want 0", overrun); end
  endtask

  task automatic test_reset_mid();
    reset = 1'b1; clr = 1'b1; wr_en = 1'b1; rd_en = 1'b1; wr_data = 8'h99;
    step();
    reset = 1'b0; clr = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL mid_rst_count got %0d want 0", count); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL mid_rst_empty got %0b want 1", empty); end
    checks++; if (rd_data !== 8'h00) begin errors++; $display("FAIL mid_rst_data got %0h want 0", rd_data); end
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid got %0b want 0", rd_valid); end
  endtask

  initial begin
    reset = 1'b1; clr = 1'b0; fifo_en = 1'b1; wr_en = 1'b0; rd_en = 1'b0;
    ovr_clr = 1'b0; wr_data = '0; wr_err = '0; trig_lvl = '0;
    #1;
    test_reset();
    test_fill_drain();
    test_overrun();
    test_trigger();
    test_err();
    test_timeout();
    test_hold_mode();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 Single clock domain (clk); reset is synchronous and active-high (reset); all state changes on rising edge of clk.
REQ-002 DATA_W, default 8, received character width.
REQ-003 DEPTH, default 16, entry count; power of two, >=2; AW = log2(DEPTH).
REQ-004 ERR_W, default 3, per-character status bits {break, framing, parity}.
REQ-005 TO_CYC, default 1024, idle cycles before character timeout; >=1.
REQ-006 clk  in  1  clock.
REQ-007 reset  in  1  synchronous active-high reset.
REQ-008 clr  in  1  synchronous flush pulse.
REQ-009 fifo_en  in  1  1 = DEPTH-entry FIFO mode, 0 = single-entry holding-register mode.
REQ-010 wr_en  in  1  write strobe from receiver.
REQ-011 wr_data  in  DATA_W  received character.
REQ-012 wr_err  in  ERR_W  status bits for wr_data.
REQ-013 rd_en  in  1  read strobe from host.
REQ-014 rd_data  out  DATA_W  registered read character.
REQ-015 rd_err  out  ERR_W  registered status bits of rd_data.
REQ-016 rd_valid  out  1  one-cycle pulse, rd_data/rd_err updated.
REQ-017 trig_lvl  in  AW+1  interrupt trigger level.
REQ-018 count  out  AW+1  occupied entries.
REQ-019 full  out  1  count equals effective depth.
REQ-020 empty  out  1  count equals 0.
REQ-021 trigger  out  1  count >= max(trig_lvl,1).
REQ-022 overrun  out  1  sticky: character dropped while full.
REQ-023 ovr_clr  in  1  clears overrun.
REQ-024 err_in_fifo  out  1  at least one stored entry has nonzero status.
REQ-025 timeout  out  1  character timeout indication.

Function
REQ-026 Storage DEPTH x (DATA_W+ERR_W); binary pointers AW+1 bits wide, wrapping modulo 2*DEPTH; count = wr_ptr - rd_ptr (AW+1 bits).
REQ-027 Effective depth = DEPTH when fifo_en=1, 1 when fifo_en=0; any change of fifo_en performs the same flush as clr on the following edge.
REQ-028 Write accepted when wr_en=1 and (full=0 or read accepted same cycle); entry stored at wr_ptr[AW-1:0]; wr_ptr increments.
REQ-029 wr_en=1 with full=1 and no accepted read: character dropped, pointers unchanged, overrun set next edge.
REQ-030 Read accepted when rd_en=1 and empty=0; rd_data/rd_err loaded from rd_ptr entry next edge, rd_valid=1 for exactly that cycle, rd_ptr increments; latency 1 cycle.
REQ-031 rd_en=1 with empty=1: ignored, rd_valid=0, rd_data/rd_err hold last value.
REQ-032 Simultaneous accepted read and write: count unchanged; read of the sole entry returns the old entry, new entry stored.
REQ-033 count, full, empty, trigger, err_in_fifo are combinational from registered state only; no input-to-output paths.
REQ-034 Error counter (AW+1 bits): +1 on accepted write with wr_err!=0, -1 on accepted read of entry with status!=0, unchanged if both; err_in_fifo = (counter!=0).
REQ-035 Timeout counter: cleared on any accepted read/write or when empty; otherwise increments, saturating at TO_CYC; timeout = (counter==TO_CYC).
REQ-036 overrun clears on ovr_clr; if ovr_clr and new overrun same cycle, overrun stays 1.
REQ-037 clr (and fifo_en change) zeroes pointers, error counter, timeout counter, overrun, rd_valid; clr has priority over same-cycle read/write; rd_data/rd_err hold.

Reset
REQ-038 reset=1 at clk edge: rd_data=0, rd_err=0, rd_valid=0, count=0, empty=1, full=0, trigger=0, overrun=0, err_in_fifo=0, timeout=0; reset overrides clr and all strobes, mid-operation included.

Verification
REQ-039 Defaults, fifo_en=1, write 0x00..0x0F -> full=1, count=16; read 16 -> same order, each rd_valid one cycle after rd_en, empty=1.
REQ-040 Full, write 0xAA -> dropped, overrun=1; ovr_clr -> overrun=0; next 16 reads exclude 0xAA.
REQ-041 trig_lvl=4, write 3 -> trigger=0; 4th write -> trigger=1; one read -> trigger=0.
REQ-042 Write 0x41 with wr_err=3'b001 among clean chars -> err_in_fifo=1 until that entry read, rd_err=3'b001 on its rd_valid.
REQ-043 TO_CYC=8, write one char then idle -> timeout=1 exactly 8 cycles after write; read -> timeout=0.
REQ-044 fifo_en=0, write 0x11 then 0x22 -> full after first, 0x22 dropped, overrun=1; clr with simultaneous wr_en -> count=0, empty=1.
